// File: rtl/v850_mem_pkg.sv
// Shared types and helpers for the CPU-to-DDR3 application-interface master.
// Holds the state encoding, default command codes and the 32-bit lane helpers.
package v850_mem_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    WR_CMD,
    WR_DATA,
    RD_CMD,
    RD_WAIT,
    RESP
  } state_e;

  localparam logic [2:0] CMD_WR_DEF = 3'b000;
  localparam logic [2:0] CMD_RD_DEF = 3'b001;

  // Write one 32-bit word into every lane of a 256-bit beat.
  function automatic logic [255:0] lane_replicate(input logic [31:0] word);
    return {8{word}};
  endfunction

  // Byte mask for a beat: only the bytes of the selected lane may be written.
  function automatic logic [31:0] lane_mask(input logic [3:0] be, input logic [2:0] lane);
    logic [31:0] m;
    m = '1;
    m[{lane, 2'b00} +: 4] = ~be;
    return m;
  endfunction

  function automatic logic [31:0] lane_extract(input logic [255:0] beat, input logic [2:0] lane);
    return beat[{lane, 5'b00000} +: 32];
  endfunction

endpackage

// File: rtl/ddr3_app_master.sv
// Bridges single-word CPU memory requests onto a DDR3 IP application port,
// one BL8 command per request, with a read timeout that returns an error response.
module ddr3_app_master
  import v850_mem_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter logic [2:0] CMD_WR         = CMD_WR_DEF,
  parameter logic [2:0] CMD_RD         = CMD_RD_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [31:0]  req_addr,
  input  logic [31:0]  req_wdata,
  input  logic [3:0]   req_be,
  output logic         rsp_valid,
  output logic [31:0]  rsp_rdata,
  output logic         rsp_err,
  input  logic         init_calib_complete,
  input  logic         cmd_ready,
  output logic [2:0]   cmd,
  output logic         cmd_en,
  output logic [28:0]  addr,
  output logic         burst,
  input  logic         wr_data_rdy,
  output logic [255:0] wr_data,
  output logic         wr_data_en,
  output logic         wr_data_end,
  output logic [31:0]  wr_data_mask,
  input  logic [255:0] rd_data,
  input  logic         rd_data_valid,
  input  logic         rd_data_end
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_e        r_state, w_next;
  logic [28:0]   r_addr;
  logic [2:0]    r_lane;
  logic [31:0]   r_wdata;
  logic [3:0]    r_be;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_rsp_rdata;
  logic          r_rsp_err;

  logic w_accept;
  logic w_rd_hit;
  logic w_timeout;
  logic w_unused_addr_bits;

  assign w_accept           = req_valid && req_ready;
  assign w_rd_hit           = rd_data_valid && rd_data_end;
  assign w_timeout          = (r_cnt == TMO_LAST);
  // Word-aligned and 2 GiB-limited: these address bits never reach the IP.
  assign w_unused_addr_bits = ^{req_addr[31], req_addr[1:0]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= INIT;
    else        r_state <= w_next;
  end

  // NOTE: w_next gets its default before the case so no path infers a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      INIT:    if (init_calib_complete) w_next = IDLE;
      IDLE: begin
        if (!init_calib_complete) w_next = INIT;
        else if (req_valid)       w_next = req_we ? WR_CMD : RD_CMD;
      end
      WR_CMD:  if (cmd_ready)   w_next = WR_DATA;
      WR_DATA: if (wr_data_rdy) w_next = RESP;
      RD_CMD:  if (cmd_ready)   w_next = RD_WAIT;
      RD_WAIT: if (w_rd_hit || w_timeout) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = INIT;
    endcase
  end

  // Request latch and response data; the response fields reset on each new
  // request so a write always returns zero data and no error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_lane      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_accept) begin
      r_addr      <= {req_addr[30:5], 3'b000};
      r_lane      <= req_addr[4:2];
      r_wdata     <= req_wdata;
      r_be        <= req_be;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else if (r_state == RD_WAIT) begin
      if (w_rd_hit)       r_rsp_rdata <= lane_extract(rd_data, r_lane);
      else if (w_timeout) r_rsp_err   <= 1'b1;
    end
  end

  // Counts cycles spent in RD_WAIT; saturates at the timeout value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_cnt <= '0;
    else if (r_state != RD_WAIT) r_cnt <= '0;
    else if (!w_timeout)         r_cnt <= r_cnt + 1'b1;
  end

  assign req_ready    = (r_state == IDLE) && init_calib_complete;
  assign cmd_en       = (r_state == WR_CMD) || (r_state == RD_CMD);
  assign cmd          = (r_state == RD_CMD) ? CMD_RD : CMD_WR;
  assign addr         = r_addr;
  assign burst        = 1'b1;
  assign wr_data      = lane_replicate(r_wdata);
  assign wr_data_en   = (r_state == WR_DATA);
  assign wr_data_end  = (r_state == WR_DATA);
  assign wr_data_mask = (r_state == WR_DATA) ? lane_mask(r_be, r_lane) : '0;
  assign rsp_valid    = (r_state == RESP);
  assign rsp_rdata    = r_rsp_rdata;
  assign rsp_err      = r_rsp_err;

endmodule
